// File: rtl/window_loader.sv
// Raster-to-window loader: streams pixels into KERNEL+1 rotating line buffers and
// emits KERNEL x KERNEL valid-region windows with ready/valid on both sides.
module window_loader #(
  parameter  int PIXEL_W     = 8,
  parameter  int IMAGE_WIDTH = 512,
  parameter  int KERNEL      = 3,
  localparam int NUM_BUF     = KERNEL + 1
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic                                flush,
  input  logic [PIXEL_W-1:0]                  pixel_in,
  input  logic                                pixel_in_valid,
  output logic                                pixel_in_ready,
  output logic [KERNEL*KERNEL*PIXEL_W-1:0]    window_out,
  output logic                                window_out_valid,
  input  logic                                window_out_ready,
  output logic [$clog2(NUM_BUF+1)-1:0]        lines_filled
);

  localparam int CW  = $clog2(IMAGE_WIDTH);
  localparam int PTW = $clog2(NUM_BUF);
  localparam int LFW = $clog2(NUM_BUF + 1);

  localparam logic [CW-1:0]  LAST_COL      = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0]  FIRST_WIN_COL = CW'(KERNEL - 1);
  localparam logic [LFW-1:0] LF_FULL       = LFW'(NUM_BUF);
  localparam logic [LFW-1:0] LF_PASS       = LFW'(KERNEL);

  logic [PIXEL_W-1:0] r_mem [NUM_BUF][IMAGE_WIDTH];
  logic [PIXEL_W-1:0] r_win [KERNEL][KERNEL];

  logic [CW-1:0]  r_wr_col;
  logic [PTW-1:0] r_wr_buf;
  logic [CW-1:0]  r_rd_col;
  logic [PTW-1:0] r_rd_base;
  logic [LFW-1:0] r_lines_filled;
  logic           r_win_valid;
  logic           r_pass_done;
  logic           r_run;

  logic               w_accept;
  logic               w_line_done;
  logic               w_advance;
  logic               w_release;
  logic [PTW-1:0]     w_rd_buf [KERNEL];
  logic [PIXEL_W-1:0] w_col    [KERNEL];

  function automatic logic [PTW-1:0] ptr_add(input logic [PTW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= NUM_BUF) s = s - NUM_BUF;
    return PTW'(s);
  endfunction

  assign pixel_in_ready   = r_run && (r_lines_filled < LF_FULL);
  assign window_out_valid = r_win_valid;
  assign lines_filled     = r_lines_filled;

  assign w_accept    = pixel_in_valid && pixel_in_ready;
  assign w_line_done = w_accept && (r_wr_col == LAST_COL);

  // The buffer is released only once the pass's last window is consumed; until then
  // rd_base has already moved on, so further reads are held off by r_pass_done.
  assign w_advance = (r_lines_filled >= LF_PASS) && !r_pass_done &&
                     (!r_win_valid || window_out_ready);
  assign w_release = r_pass_done && r_win_valid && window_out_ready;

  always_comb begin
    for (int unsigned r = 0; r < KERNEL; r++) begin
      w_rd_buf[r] = ptr_add(r_rd_base, int'(r));
      w_col[r]    = r_mem[w_rd_buf[r]][r_rd_col];
    end
  end

  always_comb begin
    window_out = '0;
    for (int unsigned r = 0; r < KERNEL; r++)
      for (int unsigned j = 0; j < KERNEL; j++)
        window_out[(r*KERNEL + j)*PIXEL_W +: PIXEL_W] = r_win[r][j];
  end

  always_ff @(posedge clk) begin
    if (w_accept && !flush) r_mem[r_wr_buf][r_wr_col] <= pixel_in;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_run          <= 1'b0;
      r_wr_col       <= '0;
      r_wr_buf       <= '0;
      r_rd_col       <= '0;
      r_rd_base      <= '0;
      r_lines_filled <= '0;
      r_win_valid    <= 1'b0;
      r_pass_done    <= 1'b0;
      for (int unsigned r = 0; r < KERNEL; r++)
        for (int unsigned j = 0; j < KERNEL; j++)
          r_win[r][j] <= '0;
    end else if (flush) begin
      r_run          <= 1'b1;
      r_wr_col       <= '0;
      r_wr_buf       <= '0;
      r_rd_col       <= '0;
      r_rd_base      <= '0;
      r_lines_filled <= '0;
      r_win_valid    <= 1'b0;
      r_pass_done    <= 1'b0;
      for (int unsigned r = 0; r < KERNEL; r++)
        for (int unsigned j = 0; j < KERNEL; j++)
          r_win[r][j] <= '0;
    end else begin
      r_run <= 1'b1;

      if (w_accept) begin
        if (r_wr_col == LAST_COL) begin
          r_wr_col <= '0;
          r_wr_buf <= ptr_add(r_wr_buf, 1);
        end else begin
          r_wr_col <= r_wr_col + CW'(1);
        end
      end

      unique case ({w_line_done, w_release})
        2'b10:   r_lines_filled <= r_lines_filled + LFW'(1);
        2'b01:   r_lines_filled <= r_lines_filled - LFW'(1);
        default: r_lines_filled <= r_lines_filled;
      endcase

      if (w_advance) begin
        for (int unsigned r = 0; r < KERNEL; r++) begin
          for (int unsigned j = 0; j + 1 < KERNEL; j++)
            r_win[r][j] <= r_win[r][j+1];
          r_win[r][KERNEL-1] <= w_col[r];
        end
        r_win_valid <= (r_rd_col >= FIRST_WIN_COL);
        if (r_rd_col == LAST_COL) begin
          r_rd_col    <= '0;
          r_rd_base   <= ptr_add(r_rd_base, 1);
          r_pass_done <= 1'b1;
        end else begin
          r_rd_col <= r_rd_col + CW'(1);
        end
      end else if (w_release) begin
        r_win_valid <= 1'b0;
        r_pass_done <= 1'b0;
        for (int unsigned r = 0; r < KERNEL; r++)
          for (int unsigned j = 0; j < KERNEL; j++)
            r_win[r][j] <= '0;
      end else if (r_win_valid && window_out_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  a_lf_max : assert property (@(posedge clk) disable iff (!rstN)
    r_lines_filled <= LF_FULL);
  a_lf_underflow : assert property (@(posedge clk) disable iff (!rstN)
    w_release |-> (r_lines_filled != '0));
  a_stall_stable : assert property (@(posedge clk) disable iff (!rstN)
    (r_win_valid && !window_out_ready && !flush) |=> $stable(window_out));

endmodule

// File: tb/tb_window_loader.sv
// Directed bench for window_loader: K=3/W=8 instance for the main scenarios and a
// K=5/W=12 instance for the wider single-pass check.
module tb_window_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        a_flush, a_valid, a_oready, a_pready, a_wvalid;
  logic [7:0]  a_pix;
  logic [71:0] a_wout;
  logic [2:0]  a_lf;

  logic         b_flush, b_valid, b_oready, b_pready, b_wvalid;
  logic [7:0]   b_pix;
  logic [199:0] b_wout;
  logic [2:0]   b_lf;

  window_loader #(.PIXEL_W(8), .IMAGE_WIDTH(8), .KERNEL(3)) dut_a (
    .clk(clk), .rstN(rstN), .flush(a_flush),
    .pixel_in(a_pix), .pixel_in_valid(a_valid), .pixel_in_ready(a_pready),
    .window_out(a_wout), .window_out_valid(a_wvalid), .window_out_ready(a_oready),
    .lines_filled(a_lf)
  );

  window_loader #(.PIXEL_W(8), .IMAGE_WIDTH(12), .KERNEL(5)) dut_b (
    .clk(clk), .rstN(rstN), .flush(b_flush),
    .pixel_in(b_pix), .pixel_in_valid(b_valid), .pixel_in_ready(b_pready),
    .window_out(b_wout), .window_out_valid(b_wvalid), .window_out_ready(b_oready),
    .lines_filled(b_lf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int src_line, src_col, line_limit, m_pass, m_win, win_count, lf_m, rmode;
  int bline, bcol, bw;
  bit saw_full;

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] exp_win(input int k, input int p, input int w);
    logic [199:0] v;
    v = '0;
    for (int r = 0; r < k; r++)
      for (int j = 0; j < k; j++)
        v[(r*k + j)*8 +: 8] = 8'((p + r)*16 + (w + j));
    return v;
  endfunction

  task automatic model_reset();
    src_line = 0; src_col = 0; m_pass = 0; m_win = 0; win_count = 0; lf_m = 0;
  endtask

  // One clock of instance A: drive, score any handshake, step the model, check.
  task automatic tick_a();
    logic hs, acc, ld, rel, stall;
    logic [71:0] held;
    a_valid  = (src_line < line_limit);
    a_pix    = 8'(src_line*16 + src_col);
    a_oready = (rmode == 0) ? 1'b1 : ((rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
    #1;
    hs    = a_wvalid && a_oready;
    acc   = a_valid && a_pready;
    ld    = acc && (src_col == 7);
    rel   = hs && (m_win == 5);
    stall = a_wvalid && !a_oready;
    held  = a_wout;
    check("pixel_in_ready", a_pready, lf_m < 4);
    if (hs) begin
      check("window", a_wout, exp_win(3, m_pass, m_win));
      win_count++;
      m_win++;
      if (m_win == 6) begin m_win = 0; m_pass++; end
    end
    @(posedge clk); #1;
    if (a_flush) begin
      model_reset();
      line_limit = 0;
    end else begin
      if (acc) begin
        src_col++;
        if (src_col == 8) begin src_col = 0; src_line++; end
      end
      lf_m = lf_m + int'(ld) - int'(rel);
      if (stall) begin
        check("stall_hold", a_wout, held);
        check("stall_valid", a_wvalid, 1'b1);
      end
    end
    check("lines_filled", a_lf, lf_m);
  endtask

  task automatic flush_a();
    line_limit = 0;
    a_flush = 1'b1;
    tick_a();
    a_flush = 1'b0;
    check("flush_valid", a_wvalid, 1'b0);
    check("flush_lf", a_lf, 0);
  endtask

  task automatic run_s1();
    int n;
    line_limit = 3; rmode = 0;
    for (int i = 0; i < 100 && a_lf != 3; i++) tick_a();
    check("s1_lf3", a_lf, 3);
    n = 0;
    while (n < 10 && !a_wvalid) begin tick_a(); n++; end
    check("s1_first_latency", n, 3);
    check("s1_first_window", a_wout, 72'h222120121110020100);
    repeat (20) tick_a();
    check("s1_win_count", win_count, 6);
    check("s1_lf_after", a_lf, 2);
  endtask

  task automatic tick_b();
    logic acc;
    b_valid  = (bline < 5);
    b_pix    = 8'(bline*16 + bcol);
    b_oready = 1'b1;
    #1;
    acc = b_valid && b_pready;
    if (b_wvalid) begin
      check("b_window", b_wout, exp_win(5, 0, bw));
      bw++;
    end
    @(posedge clk); #1;
    if (acc) begin
      bcol++;
      if (bcol == 12) begin bcol = 0; bline++; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    rstN = 1'b0; a_flush = 1'b0; a_valid = 1'b0; a_oready = 1'b1; a_pix = '0;
    b_flush = 1'b0; b_valid = 1'b0; b_oready = 1'b1; b_pix = '0;
    rmode = 0; line_limit = 0; bline = 0; bcol = 0; bw = 0;
    model_reset();

    // Reset values
    #12;
    check("rst_valid", a_wvalid, 1'b0);
    check("rst_lf", a_lf, 0);
    check("rst_ready", a_pready, 1'b0);
    check("rst_window", a_wout, 0);
    #6 rstN = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", a_pready, 1'b1);

    // 1: three lines, one pass
    run_s1();

    // 2: six lines back to back, buffers fill and rotate
    flush_a();
    rmode = 0; line_limit = 6; saw_full = 0;
    for (int i = 0; i < 400 && win_count < 24; i++) begin
      tick_a();
      if (a_lf == 3'd4 && !a_pready) saw_full = 1;
    end
    repeat (10) tick_a();
    check("s2_full_seen", saw_full, 1'b1);
    check("s2_win_count", win_count, 24);
    check("s2_lines_sent", src_line, 6);
    check("s2_lf_after", a_lf, 2);

    // 3: random consumer backpressure
    flush_a();
    rmode = 2; line_limit = 5;
    for (int i = 0; i < 1000 && win_count < 18; i++) tick_a();
    rmode = 0;
    repeat (10) tick_a();
    check("s3_win_count", win_count, 18);
    check("s3_lf_after", a_lf, 2);

    // 4: fourth line completes on the same edge that releases pass 0
    flush_a();
    rmode = 0; line_limit = 3;
    for (int i = 0; i < 100 && a_lf != 3; i++) tick_a();
    tick_a();
    line_limit = 4;
    repeat (8) tick_a();
    check("s4_simul_lf", a_lf, 3);
    check("s4_simul_ready", a_pready, 1'b1);
    repeat (20) tick_a();
    check("s4_win_count", win_count, 12);
    check("s4_lf_after", a_lf, 2);

    // 5: flush after the second window of a pass, then reload
    flush_a();
    rmode = 0; line_limit = 3;
    for (int i = 0; i < 100 && win_count < 2; i++) tick_a();
    check("s5_two_windows", win_count, 2);
    flush_a();
    run_s1();

    // 6: asynchronous reset mid-stream
    line_limit = 4;
    repeat (3) tick_a();
    #3 rstN = 1'b0;
    #1;
    check("arst_valid", a_wvalid, 1'b0);
    check("arst_lf", a_lf, 0);
    check("arst_ready", a_pready, 1'b0);
    check("arst_window", a_wout, 0);
    #2 rstN = 1'b1;
    model_reset();
    line_limit = 0;
    @(posedge clk); #1;
    check("arst_ready_after", a_pready, 1'b1);
    run_s1();

    // KERNEL=5, IMAGE_WIDTH=12: one pass of eight windows
    for (int i = 0; i < 200 && b_lf != 5; i++) tick_b();
    check("b_lf5", b_lf, 5);
    n = 0;
    while (n < 12 && !b_wvalid) begin tick_b(); n++; end
    check("b_first_latency", n, 5);
    repeat (30) tick_b();
    check("b_win_count", bw, 8);
    check("b_lf_after", b_lf, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
